// File: rtl/soc_bus_pkg.sv
// Shared constants and ID type for the SoC unified OBI bus.
// Holds master index assignments and the defaults used by obi_rr_arbiter.
package soc_bus_pkg;

    localparam int NUM_REQ_DEFAULT         = 3;
    localparam int MAX_OUTSTANDING_DEFAULT = 2;

    localparam int REQ_INSTR = 0;
    localparam int REQ_DATA  = 1;
    localparam int REQ_DMA   = 2;

    // A single master still needs a 1-bit ID so every vector stays legal.
    function automatic int id_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    typedef logic [id_width(NUM_REQ_DEFAULT)-1:0] obi_id_t;

endpackage

// File: rtl/obi_rr_arbiter_if.sv
// Bundle of the upstream (per-master) and downstream OBI signals around the arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding bus.
interface obi_rr_arbiter_if #(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]            m_req_i;
    logic [NUM_REQ-1:0]            m_gnt_o;
    logic [NUM_REQ*ADDR_WIDTH-1:0] m_addr_i;
    logic [NUM_REQ-1:0]            m_we_i;
    logic [NUM_REQ*4-1:0]          m_be_i;
    logic [NUM_REQ*DATA_WIDTH-1:0] m_wdata_i;
    logic [NUM_REQ-1:0]            m_rvalid_o;
    logic [DATA_WIDTH-1:0]         m_rdata_o;

    logic                          s_req_o;
    logic                          s_gnt_i;
    logic [ADDR_WIDTH-1:0]         s_addr_o;
    logic                          s_we_o;
    logic [3:0]                    s_be_o;
    logic [DATA_WIDTH-1:0]         s_wdata_o;
    logic                          s_rvalid_i;
    logic [DATA_WIDTH-1:0]         s_rdata_i;

    modport slave (
        input  m_req_i, m_addr_i, m_we_i, m_be_i, m_wdata_i, s_gnt_i, s_rvalid_i, s_rdata_i,
        output m_gnt_o, m_rvalid_o, m_rdata_o, s_req_o, s_addr_o, s_we_o, s_be_o, s_wdata_o
    );

    modport master (
        output m_req_i, m_addr_i, m_we_i, m_be_i, m_wdata_i, s_gnt_i, s_rvalid_i, s_rdata_i,
        input  m_gnt_o, m_rvalid_o, m_rdata_o, s_req_o, s_addr_o, s_we_o, s_be_o, s_wdata_o
    );

endinterface

// File: rtl/obi_id_fifo.sv
// In-order FIFO of master IDs for outstanding OBI transactions.
// head_o is meaningful only while empty_o is low.
module obi_id_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // NOTE: storage is deliberately not reset; r_count alone decides which entries are live.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push_i) r_wr_ptr <= bump(r_wr_ptr);
            if (pop_i)  r_rd_ptr <= bump(r_rd_ptr);
            case ({push_i, pop_i})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign head_o  = r_mem[r_rd_ptr];
    assign full_o  = (r_count == FULL_CNT);
    assign empty_o = (r_count == '0);

endmodule

// File: rtl/obi_rr_arbiter.sv
// Round-robin arbiter sharing one OBI slave path among NUM_REQ masters.
// Stalled requests stay locked until granted; responses are routed back via an ID FIFO.
module obi_rr_arbiter
    import soc_bus_pkg::*;
#(
    parameter int NUM_REQ         = NUM_REQ_DEFAULT,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    obi_rr_arbiter_if.slave  bus,
    output logic             busy_o
);
    localparam int ID_W = id_width(NUM_REQ);
    typedef logic [ID_W-1:0] id_t;
    localparam id_t LAST_ID = id_t'(NUM_REQ - 1);

    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] w_addr_arr;
    logic [NUM_REQ-1:0][3:0]            w_be_arr;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] w_wdata_arr;

    logic r_lock;
    id_t  r_lock_id;
    id_t  r_rr_ptr;
    id_t  w_rr_sel;
    id_t  w_sel;
    id_t  w_head;
    logic w_full;
    logic w_empty;
    logic w_s_req;
    logic w_hs;
    logic w_pop;

    assign w_addr_arr  = bus.m_addr_i;
    assign w_be_arr    = bus.m_be_i;
    assign w_wdata_arr = bus.m_wdata_i;

    // Walk offsets from the far end so the closest requester at/after the pointer wins.
    always_comb begin
        int j;
        j        = 0;
        w_rr_sel = r_rr_ptr;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            j = int'(r_rr_ptr) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (bus.m_req_i[id_t'(j)]) w_rr_sel = id_t'(j);
        end
    end

    assign w_sel   = r_lock ? r_lock_id : w_rr_sel;
    assign w_s_req = bus.m_req_i[w_sel] && !w_full;
    assign w_hs    = w_s_req && bus.s_gnt_i;
    assign w_pop   = bus.s_rvalid_i && !w_empty;

    assign bus.s_req_o   = w_s_req;
    assign bus.s_addr_o  = w_addr_arr[w_sel];
    assign bus.s_wdata_o = w_wdata_arr[w_sel];
    assign bus.s_we_o    = w_s_req && bus.m_we_i[w_sel];
    assign bus.s_be_o    = w_s_req ? w_be_arr[w_sel] : 4'b0000;
    assign bus.m_rdata_o = bus.s_rdata_i;

    // NOTE: every output gets a default before the conditional bit, so no latch is inferred.
    always_comb begin
        bus.m_gnt_o           = '0;
        bus.m_gnt_o[w_sel]    = w_hs;
        bus.m_rvalid_o        = '0;
        bus.m_rvalid_o[w_head] = w_pop;
    end

    // A presented-but-stalled request pins the selection; any other outcome releases it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_lock    <= 1'b0;
            r_lock_id <= '0;
            r_rr_ptr  <= '0;
        end else begin
            r_lock <= w_s_req && !bus.s_gnt_i;
            if (w_s_req && !bus.s_gnt_i) r_lock_id <= w_sel;
            if (w_hs) r_rr_ptr <= (w_sel == LAST_ID) ? '0 : w_sel + 1'b1;
        end
    end

    obi_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (ID_W)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_hs),
        .pop_i   (w_pop),
        .data_i  (w_sel),
        .head_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    assign busy_o = !w_empty || r_lock;

endmodule

// File: tb/tb_obi_rr_arbiter.sv
// Scoreboard bench for obi_rr_arbiter: directed scenarios plus randomized OBI traffic,
// checked every cycle against a queue-based reference model of the arbitration rules.
module tb_obi_rr_arbiter;
    import soc_bus_pkg::*;

    localparam int N  = NUM_REQ_DEFAULT;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MO = MAX_OUTSTANDING_DEFAULT;

    typedef struct packed {
        logic [N-1:0]  gnt;
        logic          sreq;
        logic [AW-1:0] addr;
        logic          we;
        logic [3:0]    be;
        logic [DW-1:0] wdata;
        logic [N-1:0]  rvalid;
        logic [DW-1:0] rdata;
        logic          busy;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_i = 1'b1;
    logic busy;

    always #5 clk = ~clk;

    obi_rr_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    obi_rr_arbiter #(
        .NUM_REQ         (N),
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst_i),
        .bus    (bus),
        .busy_o (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Master-side request state: a master holds its request and fields until granted.
    bit            pend    [N];
    logic [AW-1:0] p_addr  [N];
    bit            p_we    [N];
    logic [3:0]    p_be    [N];
    logic [DW-1:0] p_wdata [N];

    // Reference model: rotating priority start, the master stuck waiting for a grant,
    // and the list of masters owed a response in issue order.
    int   pri_start = 0;
    int   stalled   = -1;
    int   owed_q[$];
    exp_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic raise(input int k, input logic [AW-1:0] a);
        pend[k]    = 1'b1;
        p_addr[k]  = a;
        p_we[k]    = 1'($urandom_range(0, 1));
        p_be[k]    = 4'($urandom);
        p_wdata[k] = $urandom;
    endtask

    task automatic drive_cycle(input bit rst, input bit gnt, input bit rv, input logic [DW-1:0] rd);
        exp_t e;
        int   sel;
        bit   full, sreq, hs, pop;
        @(posedge clk);
        #1;
        if (rst) for (int k = 0; k < N; k++) pend[k] = 1'b0;
        rst_i = rst;
        for (int k = 0; k < N; k++) begin
            bus.m_req_i[k]              = pend[k];
            bus.m_addr_i[k*AW +: AW]    = p_addr[k];
            bus.m_we_i[k]               = p_we[k];
            bus.m_be_i[k*4 +: 4]        = p_be[k];
            bus.m_wdata_i[k*DW +: DW]   = p_wdata[k];
        end
        bus.s_gnt_i    = gnt;
        bus.s_rvalid_i = rv;
        bus.s_rdata_i  = rd;

        full = (owed_q.size() >= MO);
        sel  = -1;
        if (stalled >= 0) begin
            sel = stalled;
        end else begin
            for (int i = 0; i < N; i++)
                if (sel < 0 && pend[(pri_start + i) % N]) sel = (pri_start + i) % N;
        end
        sreq = (sel >= 0) && pend[sel] && !full;
        hs   = sreq && gnt;
        pop  = rv && (owed_q.size() > 0);

        e        = '0;
        e.sreq   = sreq;
        e.gnt    = hs ? N'(1 << sel) : '0;
        e.addr   = sreq ? p_addr[sel] : '0;
        e.we     = sreq && p_we[sel];
        e.be     = sreq ? p_be[sel] : 4'b0000;
        e.wdata  = sreq ? p_wdata[sel] : '0;
        e.rvalid = pop ? N'(1 << owed_q[0]) : '0;
        e.rdata  = rd;
        e.busy   = (owed_q.size() > 0) || (stalled >= 0);
        exp_q.push_back(e);

        if (pop) void'(owed_q.pop_front());
        if (hs) begin
            owed_q.push_back(sel);
            pri_start = (sel + 1) % N;
            pend[sel] = 1'b0;
        end
        stalled = (sreq && !gnt) ? sel : -1;
        if (rst) begin
            owed_q.delete();
            pri_start = 0;
            stalled   = -1;
        end
    endtask

    task automatic do_reset();
        drive_cycle(1'b1, 1'b0, 1'b0, '0);
    endtask

    // Monitor: every presented cycle is popped and compared against the model's prediction.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("m_gnt_o", 64'(bus.m_gnt_o), 64'(e.gnt));
            check("s_req_o", 64'(bus.s_req_o), 64'(e.sreq));
            check("s_we_o", 64'(bus.s_we_o), 64'(e.we));
            check("s_be_o", 64'(bus.s_be_o), 64'(e.be));
            check("m_rvalid_o", 64'(bus.m_rvalid_o), 64'(e.rvalid));
            check("busy_o", 64'(busy), 64'(e.busy));
            if (e.sreq) begin
                check("s_addr_o", 64'(bus.s_addr_o), 64'(e.addr));
                check("s_wdata_o", 64'(bus.s_wdata_o), 64'(e.wdata));
            end
            if (e.rvalid != '0) check("m_rdata_o", 64'(bus.m_rdata_o), 64'(e.rdata));
        end
    end

    initial begin : watchdog
        #10000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int gnt_cnt [N];
        bit rv;
        for (int k = 0; k < N; k++) begin
            pend[k] = 1'b0; p_addr[k] = '0; p_we[k] = 1'b0; p_be[k] = '0; p_wdata[k] = '0;
        end
        bus.m_req_i = '0; bus.m_addr_i = '0; bus.m_we_i = '0; bus.m_be_i = '0;
        bus.m_wdata_i = '0; bus.s_gnt_i = 1'b0; bus.s_rvalid_i = 1'b0; bus.s_rdata_i = '0;
        repeat (2) @(posedge clk);

        // Reset state with nothing requesting.
        drive_cycle(1'b0, 1'b0, 1'b0, '0);
        @(negedge clk);
        check("reset s_req_o", 64'(bus.s_req_o), 64'd0);
        check("reset busy_o", 64'(busy), 64'd0);

        // Single master: data port, gnt high, response one cycle later.
        raise(REQ_DATA, 32'h0000_0010);
        drive_cycle(1'b0, 1'b1, 1'b0, '0);
        @(negedge clk);
        check("single gnt", 64'(bus.m_gnt_o), 64'b010);
        check("single addr", 64'(bus.s_addr_o), 64'h10);
        drive_cycle(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        @(negedge clk);
        check("single rvalid", 64'(bus.m_rvalid_o), 64'b010);
        check("single rdata", 64'(bus.m_rdata_o), 64'hDEAD_BEEF);
        drive_cycle(1'b0, 1'b0, 1'b0, '0);
        @(negedge clk);
        check("single busy", 64'(busy), 64'd0);

        // Fairness: all three request continuously, responses keep the FIFO flowing.
        do_reset();
        for (int k = 0; k < N; k++) gnt_cnt[k] = 0;
        for (int c = 0; c < 6; c++) begin
            for (int k = 0; k < N; k++) if (!pend[k]) raise(k, 32'h100 + 32'(k));
            drive_cycle(1'b0, 1'b1, c > 0, $urandom);
            @(negedge clk);
            check("fair order", 64'(bus.m_gnt_o), 64'(1 << (c % 3)));
            for (int k = 0; k < N; k++) if (bus.m_gnt_o[k]) gnt_cnt[k]++;
        end
        for (int k = 0; k < N; k++) check("fair count", 64'(gnt_cnt[k]), 64'd2);

        // Stall lock: DMA stalls three cycles, instr port shows up meanwhile.
        do_reset();
        raise(REQ_DMA, 32'hA000_0002);
        for (int c = 0; c < 3; c++) begin
            if (c == 1) raise(REQ_INSTR, 32'hA000_0000);
            drive_cycle(1'b0, 1'b0, 1'b0, '0);
            @(negedge clk);
            check("stall addr", 64'(bus.s_addr_o), 64'hA000_0002);
            check("stall req", 64'(bus.s_req_o), 64'd1);
        end
        drive_cycle(1'b0, 1'b1, 1'b0, '0);
        @(negedge clk);
        check("stall gnt locked", 64'(bus.m_gnt_o), 64'b100);
        drive_cycle(1'b0, 1'b1, 1'b0, '0);
        @(negedge clk);
        check("stall gnt next", 64'(bus.m_gnt_o), 64'b001);

        // FIFO full: two grants without responses block the third master.
        do_reset();
        for (int k = 0; k < N; k++) raise(k, 32'h200 + 32'(k));
        drive_cycle(1'b0, 1'b1, 1'b0, '0);
        drive_cycle(1'b0, 1'b1, 1'b0, '0);
        drive_cycle(1'b0, 1'b1, 1'b0, '0);
        @(negedge clk);
        check("full s_req", 64'(bus.s_req_o), 64'd0);
        check("full gnt", 64'(bus.m_gnt_o), 64'd0);
        drive_cycle(1'b0, 1'b1, 1'b1, 32'h1234_5678);
        @(negedge clk);
        check("full pop rvalid", 64'(bus.m_rvalid_o), 64'b001);
        check("full pop s_req", 64'(bus.s_req_o), 64'd0);
        drive_cycle(1'b0, 1'b1, 1'b0, '0);
        @(negedge clk);
        check("full resume gnt", 64'(bus.m_gnt_o), 64'b100);

        // Spurious response with nothing outstanding.
        do_reset();
        drive_cycle(1'b0, 1'b0, 1'b1, 32'h5555_AAAA);
        @(negedge clk);
        check("oob rvalid", 64'(bus.m_rvalid_o), 64'd0);

        // Reset with two outstanding, then a stale response.
        raise(0, 32'h300); raise(1, 32'h304);
        drive_cycle(1'b0, 1'b1, 1'b0, '0);
        drive_cycle(1'b0, 1'b1, 1'b0, '0);
        do_reset();
        drive_cycle(1'b0, 1'b0, 1'b1, 32'hBAD0_BAD0);
        @(negedge clk);
        check("rst stale rvalid", 64'(bus.m_rvalid_o), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        for (int k = 0; k < N; k++) raise(k, 32'h400 + 32'(k));
        drive_cycle(1'b0, 1'b1, 1'b0, '0);
        @(negedge clk);
        check("rst ptr restart", 64'(bus.m_gnt_o), 64'b001);

        // Locked master drops its request: lock releases without a grant.
        do_reset();
        raise(1, 32'h500);
        drive_cycle(1'b0, 1'b0, 1'b0, '0);
        pend[1] = 1'b0;
        drive_cycle(1'b0, 1'b1, 1'b0, '0);
        @(negedge clk);
        check("drop gnt", 64'(bus.m_gnt_o), 64'd0);
        check("drop busy held", 64'(busy), 64'd1);
        drive_cycle(1'b0, 1'b0, 1'b0, '0);
        @(negedge clk);
        check("drop busy clear", 64'(busy), 64'd0);

        // Randomized traffic with occasional resets and spurious responses.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < N; k++) if (!pend[k] && ($urandom % 3 == 0)) raise(k, $urandom);
            rv = (owed_q.size() > 0) ? 1'($urandom % 2) : ($urandom % 8 == 0);
            drive_cycle(($urandom % 500) == 0, ($urandom % 4) != 0, rv, $urandom);
        end

        @(negedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
